// File: rtl/seg_carry_sequencer.sv
// Multi-cycle N-bit adder: walks an operand pair through one SEG-bit carry chain,
// LSB segment first, and presents sum/cout/ovf over a valid/ready handshake.

module seg_fa_chain #(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_cin,
   output logic [W-1:0] o_sum_c,
   output logic         o_cout_c,
   output logic         o_cmsb_c
);
   logic [W:0] w_full;

   assign w_full   = (W+1)'(i_a) + (W+1)'(i_b) + (W+1)'(i_cin);
   assign o_sum_c  = w_full[W-1:0];
   assign o_cout_c = w_full[W];
   // Carry into the top bit recovered from its sum bit (equals i_cin when W==1)
   assign o_cmsb_c = i_a[W-1] ^ i_b[W-1] ^ w_full[W-1];
endmodule

module seg_carry_sequencer #(
   parameter int unsigned N   = 16,
   parameter int unsigned SEG = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         ovf,
   output logic         busy
);
   localparam int unsigned NSEG  = N / SEG;
   localparam int unsigned IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSEG - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [N-1:0]       r_a;
   logic [N-1:0]       r_b;
   logic [N-1:0]       r_sum;
   logic               r_carry;
   logic               r_cout;
   logic               r_ovf;
   logic [IDX_W-1:0]   r_idx;
   logic               w_accept;
   logic               w_last;
   logic [SEG-1:0]     w_slice_sum;
   logic               w_slice_cout;
   logic               w_slice_cmsb;
   int unsigned        w_base;

   assign w_base = 32'(r_idx) * SEG;

   seg_fa_chain #(.W(SEG)) u_chain (
      .i_a      (r_a[w_base +: SEG]),
      .i_b      (r_b[w_base +: SEG]),
      .i_cin    (r_carry),
      .o_sum_c  (w_slice_sum),
      .o_cout_c (w_slice_cout),
      .o_cmsb_c (w_slice_cmsb)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state and handshake decode; DONE with out_ready may accept back-to-back
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (r_idx == LAST_IDX) begin
               w_last      = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               in_ready = 1'b1;
               if (in_valid) begin
                  w_accept    = 1'b1;
                  w_state_nxt = S_RUN;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_idx   <= '0;
      end else if (w_accept) begin
         r_a     <= a;
         r_b     <= b;
         r_carry <= cin;
         r_idx   <= '0;
      end else if (r_state == S_RUN) begin
         r_sum[w_base +: SEG] <= w_slice_sum;
         r_carry              <= w_slice_cout;
         r_idx                <= w_last ? '0 : r_idx + 1'b1;
         if (w_last) begin
            r_cout <= w_slice_cout;
            r_ovf  <= w_slice_cmsb ^ w_slice_cout;
         end
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;
   assign ovf  = r_ovf;
endmodule
